data_memory: RTL
================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit words in the array (power of two, minimum 4).
REQ-002 The block SHALL have a derived localparam AW = log2(DEPTH), giving the word-index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_read  input  1  load enable from control.
REQ-006 mem_write  input  1  store enable from control.
REQ-007 funct3  input  3  access size/sign taken from the instruction.
REQ-008 addr  input  32  byte address from the ALU result.
REQ-009 write_data  input  32  store data from rs2.
REQ-010 read_data  output  32  load result, feeding input1 of the writeback select.
REQ-011 misaligned  output  1  current access is misaligned (combinational).
REQ-012 illegal  output  1  current access uses an unsupported funct3 (combinational).
REQ-013 err_sticky  output  1  registered flag; set by any faulting access.
REQ-014 store_count  output  16  registered count of committed stores.

Function
REQ-015 Storage SHALL be DEPTH x 32-bit words, little-endian; the word index is addr[AW+1:2]; addr[31:AW+2] is ignored, so addresses wrap modulo 4*DEPTH.
REQ-016 Reads SHALL be combinational from the array; writes SHALL commit on the rising clk edge when mem_write=1 and the access is neither misaligned nor illegal.
REQ-017 Loads SHALL decode funct3 as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; LB/LH sign-extend, LBU/LHU zero-extend the selected byte/half, selected by addr[1:0].
REQ-018 Stores SHALL decode funct3 as 000 SB, 001 SH, 010 SW; SB/SH modify only the addressed byte lanes, and the other lanes keep their old value.
REQ-019 misaligned SHALL be 1 for halfword access with addr[0]=1, or word access with addr[1:0]!=00, while mem_read or mem_write is 1; otherwise 0.
REQ-020 illegal SHALL be 1 when mem_read=1 and funct3 is in {011,110,111}, or when mem_write=1 and funct3 is not in {000,001,010}; otherwise 0.
REQ-021 read_data SHALL be 32'h0 whenever mem_read=0, misaligned=1 or illegal=1.
REQ-022 A faulting store SHALL leave the array and store_count unchanged.
REQ-023 With mem_read=1 and mem_write=1 in the same cycle, read_data SHALL show the pre-write contents during that cycle, and the write SHALL commit at the edge.
REQ-024 err_sticky SHALL be set at the rising edge of any cycle with misaligned|illegal=1 and SHALL hold until reset.
REQ-025 store_count SHALL increment by 1 per committed store and wrap from 16'hFFFF to 0.
REQ-026 Latency SHALL be 0 cycles for loads (same cycle) and 1 edge for store visibility: a store at edge N is readable in the cycle after N.

Reset
REQ-027 rst_n=0 SHALL immediately clear err_sticky and store_count to 0, independent of clk.
REQ-028 Array contents SHALL NOT be affected by reset.
REQ-029 Stores SHALL be inhibited while rst_n=0.
REQ-030 A store coinciding with the reset assertion edge SHALL NOT commit.
REQ-031 Writes and counting SHALL resume on the first rising clk edge after rst_n returns to 1.
REQ-032 read_data SHALL remain combinational during reset and obey REQ-021.

Verification
REQ-033 Word store/load: SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> read_data=0xDEADBEEF, store_count=1.
REQ-034 Byte lanes: SB addr=0x13 data=0x000000A5 over 0x11223344, then LW 0x10 -> 0xA5223344; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; LH 0x12 -> 0xFFFFA522.
REQ-035 Misaligned: SW addr=0x22 -> misaligned=1, word at 0x20 unchanged, err_sticky=1 after edge, store_count unchanged; LH 0x21 -> read_data=0.
REQ-036 Illegal and overlap: LW with funct3=011 -> illegal=1, read_data=0; read+write of 0x30 in the same cycle (old 0x1, new 0x2) -> read_data=0x1 that cycle, 0x2 next cycle.
REQ-037 Wrap and reset: with DEPTH=256, SW addr=0x400 hits word 0; store_count preset to 0xFFFF wraps to 0 on the next store; asserting rst_n mid-cycle clears err_sticky/store_count at once while the array retains its data.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressable, little-endian data memory for the load/store
// stage. Combinational loads, clocked stores with byte-lane merging,
// alignment / funct3 fault detection, a sticky fault flag and a store counter.
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        err_sticky,
    output logic [15:0] store_count
);

    localparam int AW = $clog2(DEPTH);

    // funct3 encodings shared by loads and stores
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic          access;
    logic          half_acc;
    logic          word_acc;
    logic          fault;
    logic          store_commit;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   wr_word;
    logic [3:0]    wr_mask;
    logic          unused_addr;

    // Upper address bits are ignored: the array wraps modulo 4*DEPTH bytes.
    assign idx         = addr[AW+1:2];
    assign unused_addr = ^addr[31:AW+2];

    // Access classification and fault detection
    always_comb begin
        access   = mem_read | mem_write;
        half_acc = (funct3 == F3_H) || (funct3 == F3_HU);
        word_acc = (funct3 == F3_W);

        misaligned = 1'b0;
        if (access) begin
            if (half_acc && addr[0])
                misaligned = 1'b1;
            if (word_acc && (addr[1:0] != 2'b00))
                misaligned = 1'b1;
        end

        illegal = 1'b0;
        if (mem_read && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)))
            illegal = 1'b1;
        if (mem_write && !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W)))
            illegal = 1'b1;

        fault = misaligned | illegal;
    end

    // Load path: lane select plus sign/zero extension, forced to zero on fault
    always_comb begin
        rd_word = mem[idx];

        case (addr[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase

        rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

        read_data = '0;
        if (mem_read && !fault) begin
            case (funct3)
                F3_B:    read_data = {{24{rd_byte[7]}}, rd_byte};
                F3_H:    read_data = {{16{rd_half[15]}}, rd_half};
                F3_W:    read_data = rd_word;
                F3_BU:   read_data = {24'h0, rd_byte};
                F3_HU:   read_data = {16'h0, rd_half};
                default: read_data = '0;
            endcase
        end
    end

    // Store path: replicate data across lanes and build the byte-lane mask
    always_comb begin
        wr_word = write_data;
        wr_mask = '0;
        case (funct3)
            F3_B: begin
                wr_word = {4{write_data[7:0]}};
                wr_mask = 4'b0001 << addr[1:0];
            end
            F3_H: begin
                wr_word = {2{write_data[15:0]}};
                wr_mask = addr[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                wr_word = write_data;
                wr_mask = 4'b1111;
            end
            default: begin
                wr_word = write_data;
                wr_mask = '0;
            end
        endcase

        // rst_n gates the commit so a store sampled during reset is dropped
        store_commit = mem_write && !fault && rst_n;
    end

    // Array write: only the masked lanes change; contents survive reset
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_mask[i])
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // Sticky fault flag and committed-store counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky  <= 1'b0;
            store_count <= '0;
        end else begin
            if (fault)
                err_sticky <= 1'b1;
            if (store_commit)
                store_count <= store_count + 16'd1;
        end
    end

endmodule
